// File: rtl/nl_term_sequencer_pkg.sv
// Shared constants, state encoding and segment geometry for the non-linear term sequencer.
package nl_term_sequencer_pkg;

    localparam int NBIT_DEF    = 7;
    localparam int MAX_OUT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    function automatic int nnl_of(input int nbit);
        return (1 << (nbit + 2)) - nbit - 4;
    endfunction

    // Segment i (1..NBIT) covers terms [seg_base(i), seg_base(i)+seg_len(i)-1].
    function automatic int seg_len(input int i);
        return (1 << (i + 1)) - 1;
    endfunction

    function automatic int seg_base(input int i);
        return (1 << (i + 1)) - i - 3;
    endfunction

    localparam int NNL_DEF  = nnl_of(NBIT_DEF);
    localparam int IDXW_DEF = $clog2(NNL_DEF);

endpackage

// File: rtl/nl_term_sequencer_if.sv
// Operand, engine and result signals of the sequencer; master = sequencer, slave = environment.
interface nl_term_sequencer_if
    import nl_term_sequencer_pkg::*;
#(
    parameter int NBIT = NBIT_DEF
);
    localparam int IDXW = $clog2(nnl_of(NBIT));

    // valid/ready: a transfer happens on a cycle where both are high; valid never waits on ready.
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            nl_req_valid;
    logic            nl_req_ready;
    logic [IDXW-1:0] nl_req_idx;
    logic [NBIT-1:0] nl_a;
    logic [NBIT-1:0] nl_b;
    logic            nl_rsp_valid;
    logic            nl_rsp_bit;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] s;
    logic            c_out;
    logic            err;

    modport master (
        input  in_valid, a, b, nl_req_ready, nl_rsp_valid, nl_rsp_bit, out_ready,
        output in_ready, nl_req_valid, nl_req_idx, nl_a, nl_b, out_valid, s, c_out, err
    );

    modport slave (
        output in_valid, a, b, nl_req_ready, nl_rsp_valid, nl_rsp_bit, out_ready,
        input  in_ready, nl_req_valid, nl_req_idx, nl_a, nl_b, out_valid, s, c_out, err
    );

endinterface

// File: rtl/nl_term_sequencer_seg_parity_acc.sv
// Folds retired term bits into a per-segment parity and flags the last term of each segment.
module seg_parity_acc
    import nl_term_sequencer_pkg::*;
#(
    parameter int NBIT = NBIT_DEF,
    parameter int SEGW = $clog2(NBIT + 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            rsp_i,
    input  logic            bit_i,
    output logic            seg_done_o,
    output logic [SEGW-1:0] seg_num_o,
    output logic            parity_o
);
    localparam int REMW = NBIT + 1;

    logic [SEGW-1:0] seg_q, seg_d;
    logic [REMW-1:0] rem_q, rem_d;
    logic            par_q, par_d;
    logic            par_n;

    assign par_n      = par_q ^ bit_i;
    assign seg_done_o = rsp_i && (rem_q == REMW'(1));
    assign seg_num_o  = seg_q;
    assign parity_o   = par_n;

    always_comb begin
        seg_d = seg_q;
        rem_d = rem_q;
        par_d = par_q;
        if (start_i) begin
            seg_d = SEGW'(1);
            rem_d = REMW'(seg_len(1));
            par_d = 1'b0;
        end else if (rsp_i) begin
            if (rem_q == REMW'(1)) begin
                // Past the carry segment the reload value is never consumed.
                seg_d = seg_q + SEGW'(1);
                rem_d = REMW'(seg_len(int'(seg_q) + 1));
                par_d = 1'b0;
            end else begin
                rem_d = rem_q - REMW'(1);
                par_d = par_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            rem_q <= '0;
            par_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            rem_q <= rem_d;
            par_q <= par_d;
        end
    end

endmodule

// File: rtl/nl_term_sequencer.sv
// Walks the shared non-linear term engine through every term index for one operand pair
// and assembles sum bits and carry-out from the per-segment term parities.
module nl_term_sequencer
    import nl_term_sequencer_pkg::*;
#(
    parameter int NBIT    = NBIT_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    nl_term_sequencer_if.master bus,
    output seq_state_e          dbg_state_o
);
    localparam int NNL  = nnl_of(NBIT);
    localparam int IDXW = $clog2(NNL);
    localparam int CNTW = IDXW + 1;
    localparam int OUTW = $clog2(MAX_OUT + 1);
    localparam int SEGW = $clog2(NBIT + 2);

    seq_state_e      state_q, state_d;
    logic [CNTW-1:0] issue_q, issue_d;
    logic [CNTW-1:0] retire_q, retire_d;
    logic [OUTW-1:0] outst_q, outst_d;
    logic [NBIT-1:0] a_q, b_q, s_q, s_d;
    logic            c_out_q, c_out_d;
    logic            err_q, err_d;

    logic            accept, req_valid, issue_fire, rsp_ok, last_retire, out_fire;
    logic            seg_done, seg_parity;
    logic [SEGW-1:0] seg_num;

    assign accept      = bus.in_valid && (state_q == ST_IDLE);
    assign req_valid   = (state_q == ST_RUN) && (issue_q < CNTW'(NNL)) && (outst_q < OUTW'(MAX_OUT));
    assign issue_fire  = req_valid && bus.nl_req_ready;
    assign rsp_ok      = bus.nl_rsp_valid && (state_q == ST_RUN) && (outst_q != '0);
    assign last_retire = rsp_ok && (retire_q == CNTW'(NNL - 1));
    assign out_fire    = (state_q == ST_DONE) && bus.out_ready;

    seg_parity_acc #(.NBIT(NBIT), .SEGW(SEGW)) u_seg_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (accept),
        .rsp_i      (rsp_ok),
        .bit_i      (bus.nl_rsp_bit),
        .seg_done_o (seg_done),
        .seg_num_o  (seg_num),
        .parity_o   (seg_parity)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)      state_d = ST_RUN;
            ST_RUN:  if (last_retire) state_d = ST_DONE;
            ST_DONE: if (out_fire)    state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_d  = issue_q;
        retire_d = retire_q;
        outst_d  = outst_q;
        s_d      = s_q;
        c_out_d  = c_out_q;
        // Any response the sequencer cannot match to an outstanding request is spurious.
        err_d    = err_q || (bus.nl_rsp_valid && !rsp_ok);
        if (accept) begin
            issue_d  = '0;
            retire_d = '0;
            outst_d  = '0;
            s_d      = '0;
            s_d[0]   = bus.a[0] ^ bus.b[0];
            c_out_d  = 1'b0;
        end else begin
            if (issue_fire) issue_d  = issue_q + CNTW'(1);
            if (rsp_ok)     retire_d = retire_q + CNTW'(1);
            outst_d = outst_q + OUTW'(issue_fire) - OUTW'(rsp_ok);
            if (seg_done) begin
                if (seg_num == SEGW'(NBIT)) begin
                    c_out_d = seg_parity;
                end else begin
                    for (int i = 1; i < NBIT; i++) begin
                        if (seg_num == SEGW'(i)) s_d[i] = a_q[i] ^ b_q[i] ^ seg_parity;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q  <= '0;
            retire_q <= '0;
            outst_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_out_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            issue_q  <= issue_d;
            retire_q <= retire_d;
            outst_q  <= outst_d;
            s_q      <= s_d;
            c_out_q  <= c_out_d;
            err_q    <= err_d;
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
        end
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.nl_req_valid = req_valid;
    assign bus.nl_req_idx   = issue_q[IDXW-1:0];
    assign bus.nl_a         = a_q;
    assign bus.nl_b         = b_q;
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.s            = s_q;
    assign bus.c_out        = c_out_q;
    assign bus.err          = err_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_nl_term_sequencer.sv
// Randomized bench for nl_term_sequencer (NBIT=2) with a behavioural term engine and
// a segment-parity reference model.
module tb_nl_term_sequencer;
    import nl_term_sequencer_pkg::*;

    localparam int NBIT    = 2;
    localparam int MAX_OUT = 4;
    localparam int NNL     = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    seq_state_e dbg_state;

    nl_term_sequencer_if #(.NBIT(NBIT)) bus ();

    nl_term_sequencer #(.NBIT(NBIT), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Engine / model state shared between the driver tasks and the engine process.
    int             lat = 1;
    bit             stall = 1'b0;
    logic [NNL-1:0] mask = '0;
    bit             job_running = 1'b0;
    int             issued = 0;
    int             responded = 0;
    int             max_outst = 0;
    bit             spur_req = 1'b0;
    bit             err_m = 1'b0;
    bit             prev_stall = 1'b0;
    logic [3:0]     prev_idx = '0;
    int             due_q[$];
    bit             bit_q[$];
    logic [NBIT:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {c_out, s}: s[0] is a^b, each higher output is the XOR of its segment's terms.
    function automatic logic [NBIT:0] model(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                                            input logic [NNL-1:0] m);
        logic [NBIT:0] r;
        int            base;
        int            len;
        bit            p;
        r    = '0;
        r[0] = a[0] ^ b[0];
        base = 0;
        for (int i = 1; i <= NBIT; i++) begin
            len = 2 ** (i + 1) - 1;
            p   = 1'b0;
            for (int t = base; t < base + len; t++) p = p ^ m[t];
            if (i < NBIT) r[i] = a[i] ^ b[i] ^ p;
            else          r[i] = p;
            base += len;
        end
        return r;
    endfunction

    // Behavioural engine plus per-cycle request/err checks, all on the falling edge.
    always @(negedge clk) begin : engine
        bit exp_valid;
        int outst0;
        outst0    = issued - responded;
        exp_valid = job_running && (issued < NNL) && (outst0 < MAX_OUT);
        check("req_valid", bus.nl_req_valid, exp_valid);
        if (bus.nl_req_valid === 1'b1) check("req_idx", bus.nl_req_idx, issued);
        if (prev_stall && rst_n) begin
            check("stall_valid", bus.nl_req_valid, 1'b1);
            check("stall_idx", bus.nl_req_idx, prev_idx);
        end
        check("err", bus.err, err_m);

        bus.nl_req_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_stall = rst_n && (bus.nl_req_valid === 1'b1) && !bus.nl_req_ready;
        prev_idx   = bus.nl_req_idx;
        if (bus.nl_req_valid === 1'b1 && bus.nl_req_ready && issued < NNL) begin
            due_q.push_back(cyc + lat);
            bit_q.push_back(mask[issued]);
            issued++;
        end

        if (spur_req) begin
            bus.nl_rsp_valid = 1'b1;
            bus.nl_rsp_bit   = 1'b1;
            spur_req = 1'b0;
        end else if (due_q.size() > 0 && due_q[0] == cyc) begin
            bus.nl_rsp_valid = 1'b1;
            bus.nl_rsp_bit   = bit_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            bus.nl_rsp_valid = 1'b0;
            bus.nl_rsp_bit   = 1'b0;
        end
        if (bus.nl_rsp_valid && rst_n) begin
            if (job_running && outst0 > 0) responded++;
            else                            err_m = 1'b1;
        end
        if (job_running && (issued - responded) > max_outst) max_outst = issued - responded;
    end

    task automatic start_job(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, output int c0);
        @(posedge clk); #2;
        check("in_ready_idle", bus.in_ready, 1'b1);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        c0 = cyc;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        bus.a = NBIT'($urandom);
        bus.b = NBIT'($urandom);
        issued = 0;
        responded = 0;
        max_outst = 0;
        job_running = 1'b1;
        check("nl_a_latch", bus.nl_a, a);
        check("nl_b_latch", bus.nl_b, b);
    endtask

    task automatic run_job(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                           input logic [NNL-1:0] m, input int l, input bit st, input int hold,
                           input int exp_lat, input bit use_lit, input logic [NBIT:0] lit);
        int            c0;
        int            n;
        logic [NBIT:0] got;
        logic [NBIT:0] want;
        mask  = m;
        lat   = l;
        stall = st;
        exp_q.push_back(model(a, b, m));
        start_job(a, b, c0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 3000) begin
            check("in_ready_busy", bus.in_ready, 1'b0);
            @(posedge clk); #2;
            n++;
        end
        job_running = 1'b0;
        stall = 1'b0;
        check("done_reached", bus.out_valid, 1'b1);
        want = exp_q.pop_front();
        if (exp_lat >= 0) check("out_latency", cyc - c0, exp_lat);
        got = {bus.c_out, bus.s};
        check("result", got, want);
        if (use_lit) check("result_literal", got, lit);
        repeat (hold) begin
            @(posedge clk); #2;
            check("result_stable", {bus.c_out, bus.s}, got);
            check("out_valid_hold", bus.out_valid, 1'b1);
            check("in_ready_done", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        bus.out_ready = 1'b0;
        check("in_ready_after", bus.in_ready, 1'b1);
        check("out_valid_after", bus.out_valid, 1'b0);
        check("result_held", {bus.c_out, bus.s}, want);
    endtask

    task automatic reset_mid_run();
        int c0;
        int n;
        mask  = NNL'($urandom);
        lat   = 6;
        stall = 1'b0;
        start_job(2'b11, 2'b10, c0);
        while (cyc < c0 + 4) begin
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        job_running = 1'b0;
        err_m = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_req_valid", bus.nl_req_valid, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_result", {bus.c_out, bus.s}, 0);
        check("rst_nl_ab", {bus.nl_a, bus.nl_b}, 0);
        check("rst_req_idx", bus.nl_req_idx, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(posedge clk); #2;
        rst_n = 1'b1;
        n = 0;
        while (due_q.size() > 0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("late_rsp_drained", due_q.size(), 0);
        repeat (2) @(posedge clk);
        #2;
        check("late_rsp_err", bus.err, 1'b1);
    endtask

    initial begin
        logic [NBIT-1:0] ra;
        logic [NBIT-1:0] rb;
        logic [NNL-1:0]  rm;
        int              rl;
        bit              rs;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #3;
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_req_valid", bus.nl_req_valid, 1'b0);
        check("reset_outputs", {bus.err, bus.c_out, bus.s, bus.nl_a, bus.nl_b, bus.nl_req_idx}, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed latency-1 jobs with hand-computed results.
        run_job(2'b11, 2'b01, 10'b0, 1, 1'b0, 0, 12, 1'b1, 3'b010);
        run_job(2'b00, 2'b00, 10'b00_0000_0010, 1, 1'b0, 0, 12, 1'b1, 3'b010);
        run_job(2'b00, 2'b00, 10'b10_0001_0000, 1, 1'b0, 0, 12, 1'b1, 3'b000);
        run_job(2'b00, 2'b00, 10'b10_0000_0000, 1, 1'b0, 0, 12, 1'b1, 3'b100);

        // Long engine latency: same result, bounded outstanding requests.
        run_job(2'b11, 2'b01, 10'b0, 6, 1'b0, 0, -1, 1'b1, 3'b010);
        check("outst_peak", max_outst, MAX_OUT);
        run_job(2'b00, 2'b00, 10'b10_0000_0000, 6, 1'b0, 0, -1, 1'b1, 3'b100);

        // Request back-pressure and a held-off result consumer.
        run_job(2'b10, 2'b11, 10'b01_1010_0110, 2, 1'b1, 5, -1, 1'b0, 3'b000);

        for (int k = 0; k < 8; k++) begin
            ra = NBIT'($urandom);
            rb = NBIT'($urandom);
            rm = NNL'($urandom);
            rl = $urandom_range(1, 6);
            rs = 1'($urandom_range(0, 1));
            run_job(ra, rb, rm, rl, rs, $urandom_range(0, 3), (rl == 1 && !rs) ? 12 : -1, 1'b0, '0);
        end

        // Spurious response while idle, then a normal job.
        @(posedge clk); #2;
        spur_req = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("spur_err", bus.err, 1'b1);
        run_job(2'b01, 2'b11, 10'b11_0000_0101, 1, 1'b0, 1, 12, 1'b0, '0);
        check("spur_err_sticky", bus.err, 1'b1);

        reset_mid_run();
        run_job(2'b11, 2'b01, 10'b0, 1, 1'b0, 0, 12, 1'b1, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1);
    end

endmodule
